// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: FSM encoding and pipeline constants shared by conv_mac_unit.
// Macro CONV_MAC_REQUANT_EN: adds the requant register stage, so the flush takes one more cycle.
package conv_mac_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;
`ifdef CONV_MAC_REQUANT_EN
    localparam int PIPE_DEPTH = 3;
`else
    localparam int PIPE_DEPTH = 2;
`endif
    // Flush counter value on which the output register loads.
    localparam logic [1:0] FLUSH_LAST = 2'(PIPE_DEPTH - 1);
    localparam int SHIFT_W = 5;
endpackage

// File: rtl/conv_mac_unit_if.sv
// conv_mac_unit_if: config, input-beat and output handshake bundle for conv_mac_unit.
// master = producer/consumer side (drives beats, config, clear, out_ready);
// slave  = the MAC engine (drives in_ready, dout, out_valid, busy).
interface conv_mac_unit_if #(
    parameter int LANES                 = 16,
    parameter int WEIGHT_PRECISION      = 8,
    parameter int FEATURE_MAP_PRECISION = 8,
    parameter int BIAS_PRECISION        = 32,
    parameter int ACC_PRECISION         = 32,
    parameter int BEAT_W                = 8
);
    logic                                   clear;
    logic [BEAT_W-1:0]                      cfg_beats;
    logic                                   cfg_bias_en;
    logic [4:0]                             cfg_shift;
    logic                                   cfg_relu;
    logic [LANES-1:0]                       lane_mask;
    logic [WEIGHT_PRECISION*LANES-1:0]      din_weight;
    logic [FEATURE_MAP_PRECISION*LANES-1:0] din_fm;
    logic [BIAS_PRECISION-1:0]              din_bias;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [ACC_PRECISION-1:0]               dout;
    logic                                   out_valid;
    logic                                   out_ready;
    logic                                   busy;

    modport master (
        output clear, cfg_beats, cfg_bias_en, cfg_shift, cfg_relu, lane_mask,
               din_weight, din_fm, din_bias, in_valid, out_ready,
        input  in_ready, dout, out_valid, busy
    );
    modport slave (
        input  clear, cfg_beats, cfg_bias_en, cfg_shift, cfg_relu, lane_mask,
               din_weight, din_fm, din_bias, in_valid, out_ready,
        output in_ready, dout, out_valid, busy
    );
endinterface

// File: rtl/conv_mac_adder_tree.sv
// conv_mac_adder_tree: combinational log2(LANES)-level reduction of LANES products, wrapping at ACC_W.
// Ports: i_prod = LANES packed ACC_W-bit products (lane p at [p*ACC_W +: ACC_W]); o_sum = wrapped sum.
module conv_mac_adder_tree #(
    parameter int LANES = 16,
    parameter int ACC_W = 32
) (
    input  logic [LANES*ACC_W-1:0] i_prod,
    output logic [ACC_W-1:0]       o_sum
);
    logic [ACC_W-1:0] w_node [LANES];

    // Each level folds pairs in place; node i reads 2i/2i+1, which are never overwritten earlier in the level.
    always_comb begin
        for (int i = 0; i < LANES; i++) w_node[i] = i_prod[i*ACC_W +: ACC_W];
        for (int s = LANES / 2; s > 0; s = s / 2)
            for (int i = 0; i < s; i++) w_node[i] = w_node[2*i] + w_node[2*i+1];
        o_sum = w_node[0];
    end
endmodule

// File: rtl/conv_mac_unit.sv
// conv_mac_unit: multi-beat LANES-wide multiply-accumulate with bias, optional requant and valid/ready on both sides.
// Ports: clk, rst_n (async active-low); bus (conv_mac_unit_if.slave) carries clear, cfg_*, lane_mask,
//        din_weight/din_fm/din_bias with in_valid/in_ready, and dout/out_valid/out_ready plus busy.
// Macro CONV_MAC_REQUANT_EN: round/shift/ReLU/saturate stage after accumulation (+1 cycle latency).
module conv_mac_unit import conv_mac_pkg::*; #(
    parameter int LANES                 = 16,
    parameter int WEIGHT_PRECISION      = 8,
    parameter int FEATURE_MAP_PRECISION = 8,
    parameter int BIAS_PRECISION        = 32,
    parameter int ACC_PRECISION         = 32,
    parameter int OUT_PRECISION         = 8,
    parameter int BEAT_W                = 8
) (
    input logic            clk,
    input logic            rst_n,
    conv_mac_unit_if.slave bus
);
    localparam int W  = WEIGHT_PRECISION;
    localparam int F  = FEATURE_MAP_PRECISION;
    localparam int A  = ACC_PRECISION;
    localparam int PW = W + F;

    state_t                 r_state, w_next;
    logic [BEAT_W-1:0]      r_beats, r_cnt;
    logic                   r_bias_en;
    logic [BIAS_PRECISION-1:0] r_bias;
    logic [LANES-1:0]       r_mask_cfg, r_mask;
    logic [W*LANES-1:0]     r_w;
    logic [F*LANES-1:0]     r_fm;
    logic                   r_s1_valid, r_s1_last;
    logic [A-1:0]           r_acc, r_dout;
    logic [1:0]             r_flush;
    logic [LANES*A-1:0]     w_prod;
    logic [A-1:0]           w_sum, w_bias, w_res;
    logic [BEAT_W-1:0]      w_beats_in;
    logic                   w_first, w_accept, w_last;

    assign w_first    = r_state == S_IDLE;
    assign w_beats_in = bus.cfg_beats == '0 ? BEAT_W'(1) : bus.cfg_beats;
    assign w_accept   = bus.in_valid && bus.in_ready && !bus.clear;
    // The first beat is compared against the live config, later beats against the latched group length.
    assign w_last     = w_first ? w_beats_in == BEAT_W'(1) : r_cnt + BEAT_W'(1) == r_beats;

    assign bus.in_ready  = r_state == S_IDLE || r_state == S_ACCUM;
    assign bus.out_valid = r_state == S_OUT;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.dout      = r_dout;

    genvar p;
    generate
        for (p = 0; p < LANES; p++) begin : g_lane
            logic signed [PW-1:0] w_mul;
            assign w_mul = $signed({{F{r_w[(p+1)*W-1]}}, r_w[(p+1)*W-1 -: W]})
                         * $signed({{W{r_fm[(p+1)*F-1]}}, r_fm[(p+1)*F-1 -: F]});
            assign w_prod[(p+1)*A-1 -: A] = r_mask[p] ? {{(A-PW){w_mul[PW-1]}}, w_mul} : '0;
        end
        if (BIAS_PRECISION >= A) begin : g_bias_trunc
            assign w_bias = r_bias[A-1:0];
        end else begin : g_bias_ext
            assign w_bias = {{(A-BIAS_PRECISION){r_bias[BIAS_PRECISION-1]}}, r_bias};
        end
    endgenerate

    conv_mac_adder_tree #(.LANES(LANES), .ACC_W(A)) u_tree (
        .i_prod (w_prod),
        .o_sum  (w_sum)
    );

`ifdef CONV_MAC_REQUANT_EN
    localparam logic signed [A-1:0] SAT_MAX = A'((64'sd1 <<< (OUT_PRECISION - 1)) - 64'sd1);
    localparam logic signed [A-1:0] SAT_MIN = ~SAT_MAX;
    logic [SHIFT_W-1:0]     r_shift;
    logic                   r_relu;
    logic [A-1:0]           r_rq;
    logic signed [A-1:0]    w_rnd, w_shr, w_relu, w_sat;

    // Round half up: bias by half an LSB of the shifted result before the arithmetic shift.
    assign w_rnd  = r_shift == '0 ? '0 : A'(1) << (r_shift - SHIFT_W'(1));
    assign w_shr  = ($signed(r_acc) + w_rnd) >>> r_shift;
    assign w_relu = r_relu && w_shr[A-1] ? '0 : w_shr;
    assign w_sat  = w_relu > SAT_MAX ? SAT_MAX : w_relu < SAT_MIN ? SAT_MIN : w_relu;
    assign w_res  = r_rq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_rq    <= '0;
        end else if (bus.clear) begin
            r_rq    <= '0;
        end else begin
            r_rq    <= w_sat;
            if (w_accept && w_first) begin
                r_shift <= bus.cfg_shift;
                r_relu  <= bus.cfg_relu;
            end
        end
    end
`else
    assign w_res = r_acc;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = w_last ? S_FLUSH : S_ACCUM;
            S_ACCUM: if (w_accept && w_last) w_next = S_FLUSH;
            S_FLUSH: if (r_flush == FLUSH_LAST) w_next = S_OUT;
            S_OUT:   if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beats    <= '0;
            r_cnt      <= '0;
            r_bias_en  <= 1'b0;
            r_bias     <= '0;
            r_mask_cfg <= '0;
            r_mask     <= '0;
            r_w        <= '0;
            r_fm       <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_acc      <= '0;
            r_dout     <= '0;
            r_flush    <= '0;
        end else if (bus.clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_acc      <= '0;
            r_flush    <= '0;
        end else begin
            r_state    <= w_next;
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept && w_last;
            r_flush    <= r_state == S_FLUSH ? r_flush + 2'd1 : 2'd0;
            if (w_accept) begin
                r_w    <= bus.din_weight;
                r_fm   <= bus.din_fm;
                r_mask <= w_first ? bus.lane_mask : r_mask_cfg;
                r_cnt  <= w_first ? BEAT_W'(1) : r_cnt + BEAT_W'(1);
            end
            if (w_accept && w_first) begin
                r_beats    <= w_beats_in;
                r_bias_en  <= bus.cfg_bias_en;
                r_bias     <= bus.din_bias;
                r_mask_cfg <= bus.lane_mask;
            end
            // Bias rides with the group's last beat so it is added exactly once.
            if (r_state == S_OUT && bus.out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_s1_valid) begin
                r_acc <= r_acc + w_sum + (r_s1_last && r_bias_en ? w_bias : '0);
            end
            if (r_state == S_FLUSH && r_flush == FLUSH_LAST) r_dout <= w_res;
        end
    end
endmodule

// File: tb/tb_conv_mac_unit.sv
// tb_conv_mac_unit: directed self-checking bench for conv_mac_unit (default LANES=16, 8-bit operands).
module tb_conv_mac_unit;
`ifdef CONV_MAC_REQUANT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    conv_mac_unit_if bus ();

    conv_mac_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Expected dout for a raw accumulator value; identity unless the requant stage is built in.
    function automatic logic [31:0] expect_out(input int raw, input int sh, input bit relu);
        int v;
        v = raw;
`ifdef CONV_MAC_REQUANT_EN
        v = (v + (sh > 0 ? (1 << (sh - 1)) : 0)) >>> sh;
        if (relu && v < 0) v = 0;
        v = v > 127 ? 127 : v < -128 ? -128 : v;
`else
        if (sh < 0 && relu) v = 0;
`endif
        return 32'(v);
    endfunction

    task automatic set_cfg(input logic [7:0] beats, input logic bias_en, input logic [31:0] bias,
                           input logic [15:0] mask, input logic [4:0] sh, input logic relu);
        bus.cfg_beats   = beats;
        bus.cfg_bias_en = bias_en;
        bus.din_bias    = bias;
        bus.lane_mask   = mask;
        bus.cfg_shift   = sh;
        bus.cfg_relu    = relu;
    endtask

    task automatic beat(input logic [7:0] wv, input logic [7:0] fv);
        bus.din_weight = {16{wv}};
        bus.din_fm     = {16{fv}};
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
    endtask

    // Called #1 after the edge that accepted the group's last beat.
    task automatic await_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n + 1), 32'(LAT));
    endtask

    task automatic take(input string tag, input logic [31:0] exp);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " dout"}, bus.dout, exp);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " drained"}, 32'(bus.out_valid), 32'd0);
        check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.clear      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.din_weight = '0;
        bus.din_fm     = '0;
        set_cfg(8'd1, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset dout", bus.dout, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, 16 lanes of 2*3.
        set_cfg(8'd1, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd2, 8'd3);
        check("t1 busy", 32'(bus.busy), 32'd1);
        check("t1 flush in_ready", 32'(bus.in_ready), 32'd0);
        await_out("t1");
        take("t1", expect_out(96, 0, 0));

        // Four beats with a bubble and mid-group config changes that must be ignored.
        set_cfg(8'd4, 1'b1, 32'd100, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd1, 8'd1);
        set_cfg(8'd1, 1'b0, 32'd0, 16'h0000, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t2 bubble busy", 32'(bus.busy), 32'd1);
        check("t2 bubble in_ready", 32'(bus.in_ready), 32'd1);
        beat(8'd1, 8'd2);
        beat(8'd1, 8'd3);
        beat(8'd1, 8'd4);
        await_out("t2");
        take("t2", expect_out(260, 0, 0));

        // Lanes 0..3 carry -128*-128, masked lanes carry junk; output stalled 5 cycles.
        set_cfg(8'd1, 1'b0, 32'd0, 16'h000F, 5'd0, 1'b0);
        bus.din_weight = {{12{8'h07}}, {4{8'h80}}};
        bus.din_fm     = {{12{8'h09}}, {4{8'h80}}};
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        await_out("t3");
        for (int i = 0; i < 5; i++) begin
            check("t3 hold out_valid", 32'(bus.out_valid), 32'd1);
            check("t3 hold dout", bus.dout, expect_out(65536, 0, 0));
            check("t3 hold in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        take("t3", expect_out(65536, 0, 0));

        // cfg_beats=0 acts as one beat; 16*(1*-1) + bias -5.
        set_cfg(8'd0, 1'b1, -32'sd5, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd1, 8'hFF);
        await_out("t4");
        take("t4", expect_out(-21, 0, 0));

        // Clear after 2 of 4 beats drops the group; a fresh group is unaffected.
        set_cfg(8'd4, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd5, 8'd5);
        beat(8'd5, 8'd5);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check("t5 clear busy", 32'(bus.busy), 32'd0);
        check("t5 clear in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("t5 no output", 32'(bus.out_valid), 32'd0);
        set_cfg(8'd1, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd3, 8'd5);
        await_out("t5");
        take("t5", expect_out(240, 0, 0));

        // Clear while an output is pending drops it.
        beat(8'd1, 8'd1);
        await_out("t6");
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check("t6 dropped out_valid", 32'(bus.out_valid), 32'd0);
        check("t6 dropped busy", 32'(bus.busy), 32'd0);

        // Async reset mid-group clears everything at once, including dout.
        set_cfg(8'd4, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd2, 8'd2);
        rst_n = 1'b0;
        #1;
        check("t7 reset busy", 32'(bus.busy), 32'd0);
        check("t7 reset out_valid", 32'(bus.out_valid), 32'd0);
        check("t7 reset dout", bus.dout, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_cfg(8'd1, 1'b0, 32'd0, 16'hFFFF, 5'd0, 1'b0);
        beat(8'd2, 8'd2);
        await_out("t7");
        take("t7", expect_out(64, 0, 0));

        // Single-lane values exercising shift/round, saturation and ReLU.
        set_cfg(8'd1, 1'b0, 32'd0, 16'h0001, 5'd3, 1'b1);
        beat(8'd100, 8'd10);
        await_out("t8a");
        take("t8a", expect_out(1000, 3, 1));
        set_cfg(8'd1, 1'b0, 32'd0, 16'h0001, 5'd0, 1'b0);
        beat(8'd100, 8'd50);
        await_out("t8b");
        take("t8b", expect_out(5000, 0, 0));
        set_cfg(8'd1, 1'b0, 32'd0, 16'h0001, 5'd0, 1'b1);
        beat(8'hFC, 8'd10);
        await_out("t8c");
        take("t8c", expect_out(-40, 0, 1));
        set_cfg(8'd1, 1'b0, 32'd0, 16'h0001, 5'd0, 1'b0);
        beat(8'hFC, 8'd10);
        await_out("t8d");
        take("t8d", expect_out(-40, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_mac_unit.md
# conv_mac_unit

Parametrised multi-beat multiply-accumulate engine for the convolution datapath, successor to the single-beat 16-lane conv PE. Each beat multiplies LANES weight/feature-map pairs, reduces them through an adder tree and accumulates across a configurable number of beats, so one output can span more than LANES inputs. The unit adds bias once per output, optionally requantises, and uses valid/ready handshakes on both sides so the feature-map fetcher and the output writer can stall it.

## Interface
- LANES, 16, parallel multiplier lanes (power of two, 2..64)
- WEIGHT_PRECISION, 8, signed weight width
- FEATURE_MAP_PRECISION, 8, signed feature-map width
- BIAS_PRECISION, 32, signed bias width
- ACC_PRECISION, 32, signed accumulator and output width
- OUT_PRECISION, 8, saturated result width (used only with requant)
- BEAT_W, 8, width of beat counter/config

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort, highest priority
- cfg_beats  in  BEAT_W  beats per output; 0 treated as 1
- cfg_bias_en  in  1  add din_bias to this output
- cfg_shift  in  5  requant right shift
- cfg_relu  in  1  clamp negatives to 0 (requant only)
- lane_mask  in  LANES  1 = lane contributes; 0 = product forced to 0
- din_weight  in  WEIGHT_PRECISION*LANES  lane p at bits [(p+1)*W-1 -: W]
- din_fm  in  FEATURE_MAP_PRECISION*LANES  same packing
- din_bias  in  BIAS_PRECISION  bias for current output
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- dout  out  ACC_PRECISION  signed result
- out_valid  out  1  dout valid, held until out_ready
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, FLUSH, OUT.
- IDLE: accumulator 0, in_ready=1. First accepted beat latches cfg_beats, cfg_bias_en, cfg_shift, cfg_relu, lane_mask, din_bias for the whole output; beat counter loads 1; go ACCUM (or FLUSH if latched beats==1).
- ACCUM: in_ready=1; each accepted beat increments counter; beat making counter == latched beats -> FLUSH. Config inputs ignored mid-group.
- FLUSH: in_ready=0; wait for in-flight beats to leave the pipeline (2 cycles; 3 with requant); then load output register, go OUT.
- OUT: out_valid=1, dout stable; on out_ready go IDLE (accumulator cleared same edge).
- Arithmetic: product signed W+F bits, sign-extended to ACC_PRECISION; masked lanes give 0; tree sum and accumulation wrap modulo 2^ACC_PRECISION; bias sign-extended/truncated to ACC_PRECISION, added once at the final accumulate when latched cfg_bias_en=1.
- clear: any state -> IDLE next edge; pipeline valids, accumulator, counter zeroed; pending output dropped, out_valid=0 next cycle.
- in_valid low mid-group: pipeline bubbles, accumulator holds, no timeout.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, dout=0, busy=0; all internal registers 0.
- Pipeline: S1 registers operands on accept; S2 multiplies, reduces, adds into accumulator.
- Latency: last beat accepted at cycle t -> out_valid at t+3 (t+4 with requant).
- Throughput: one output per cfg_beats+3 cycles minimum (+1 with requant) with out_ready tied high.
- out_valid && !out_ready: dout and out_valid held; in_ready stays 0.
- Reset asserted mid-operation: all state cleared immediately; no output emitted.

## Configuration
- CONV_MAC_REQUANT_EN defined: extra register stage after accumulation; arithmetic right shift by cfg_shift with round-half-up (add 1<<(shift-1) when shift>0), then ReLU if cfg_relu, then saturate to signed OUT_PRECISION, sign-extended onto dout.
- Undefined: dout is the raw wrapped accumulator; cfg_shift and cfg_relu ignored; no extra stage.

## Structure
- Package conv_mac_pkg: state encoding constants, pipeline depth constant (2/3 by macro), lane-slicing helper widths.
- Sub-module conv_mac_adder_tree: pipelining-free log2(LANES)-level signed reduction of LANES products to ACC_PRECISION.

## Test plan
- LANES=16, all weights 2, fm 3, cfg_beats=1, bias off -> dout=96, out_valid at t+3.
- cfg_beats=4, weights 1, fm 1..4 per beat, bias 100 -> dout=16*(1+2+3+4)+100=260.
- lane_mask=0x000F, weights -128, fm -128, beats=1 -> dout=4*16384=65536; masked lanes ignored.
- out_ready low 5 cycles in OUT -> dout/out_valid held, in_ready=0; next group accepted after out_ready.
- clear asserted in ACCUM after 2 of 4 beats -> no output; next 1-beat group gives correct fresh result.
- With CONV_MAC_REQUANT_EN: accumulator 1000, shift 3 -> 125; accumulator 5000, shift 0 -> 127 saturated; -40 with relu -> 0.
